// File: rtl/cache_bus_if.sv
// cache_bus_if: single-word strobe/acknowledge bus between the cache bus master and the data RAM slave.
interface cache_bus_if;
  logic cyc_o, stb_o, we_o, ack_i;
  logic [3:0] sel_o;
  logic [31:0] addr_o, data_o, data_i;
  modport master (output cyc_o, stb_o, we_o, sel_o, addr_o, data_o, input data_i, ack_i);
  modport slave (input cyc_o, stb_o, we_o, sel_o, addr_o, data_o, output data_i, ack_i);
endinterface

// File: rtl/cache_bus_master.sv
// cache_bus_master: turns cache line refill/writeback requests into single-word bus beats.
// Define BUS_TIMEOUT_EN to abort a beat that waits TIMEOUT cycles for ack (err_o pulses with done_o).
module cache_bus_master #(
  parameter int WORDS = 4,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_we_i,
  input  logic [31:0] req_addr_i,
  output logic req_ready_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic [$clog2(WORDS)-1:0] wb_idx_o,
  input  logic [31:0] wb_data_i,
  output logic fill_we_o,
  output logic [$clog2(WORDS)-1:0] fill_idx_o,
  output logic [31:0] fill_data_o,
  cache_bus_if.master bus
);
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, BEAT, GAP, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] base, wdata;
  logic we_q, last, timeout, err_q;
  logic [IW-1:0] idx;
  assign last = idx == IW'(WORDS - 1);
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tcnt;
  assign timeout = state == BEAT && !bus.ack_i && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= (state != BEAT) ? '0 : bus.ack_i ? tcnt : tcnt + TW'(1);
      err_q <= timeout ? 1'b1 : (state == DONE) ? 1'b0 : err_q;
    end
`else
  assign timeout = 1'b0;
  assign err_q = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = req_i ? BEAT : IDLE;
      BEAT: state_nxt = timeout ? DONE : !bus.ack_i ? BEAT : last ? DONE : GAP;
      GAP: state_nxt = BEAT;
      default: state_nxt = IDLE;
    endcase
  end
  // idx returns to 0 in DONE so IDLE always presents word 0 to the cache for the next writeback
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base <= '0;
      we_q <= 1'b0;
      idx <= '0;
      wdata <= '0;
      fill_we_o <= 1'b0;
      fill_idx_o <= '0;
      fill_data_o <= '0;
    end else begin
      fill_we_o <= state == BEAT && bus.ack_i && !we_q;
      if (state == BEAT && bus.ack_i && !we_q) begin
        fill_idx_o <= idx;
        fill_data_o <= bus.data_i;
      end
      if (state == IDLE && req_i) begin
        base <= req_addr_i & ~32'(WORDS * 4 - 1);
        we_q <= req_we_i;
      end
      if (state == BEAT && bus.ack_i && !last) idx <= idx + IW'(1);
      else if (state == DONE) idx <= '0;
      if (state_nxt == BEAT && state != BEAT) wdata <= wb_data_i;
    end
  always_comb begin
    req_ready_o = state == IDLE;
    busy_o = state != IDLE;
    done_o = state == DONE;
    err_o = done_o && err_q;
    wb_idx_o = idx;
    bus.cyc_o = state == BEAT || state == GAP;
    bus.stb_o = state == BEAT;
    bus.we_o = bus.cyc_o && we_q;
    bus.sel_o = bus.cyc_o ? 4'hF : 4'h0;
    bus.addr_o = base + 32'({idx, 2'b00});
    bus.data_o = wdata;
  end
endmodule

// File: tb/tb_cache_bus_master.sv
// tb_cache_bus_master: directed refill, writeback, held-request, stalled-slave and mid-transfer reset
// scenarios against a RAM slave model; a negedge monitor checks DUT outputs against queued expectations.
module tb_cache_bus_master;
  localparam int WORDS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_i = 1'b0, req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic req_ready_o, busy_o, done_o, err_o, fill_we_o;
  logic [1:0] wb_idx_o, fill_idx_o;
  logic [31:0] wb_data_i, fill_data_o;
  cache_bus_if bus();
  cache_bus_master #(.WORDS(WORDS), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_idx_o(wb_idx_o), .wb_data_i(wb_data_i), .fill_we_o(fill_we_o),
    .fill_idx_o(fill_idx_o), .fill_data_o(fill_data_o), .bus(bus)
  );
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [31:0] cache_line [4];
  logic [31:0] rd [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
  logic [31:0] wd [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  assign wb_data_i = cache_line[wb_idx_o];

  // RAM slave: registered ack one cycle after stb, optional extra wait on one address, or no ack at all
  logic [31:0] delay_addr = '1;
  int delay_n = 0;
  bit nack = 1'b0;
  int wcnt;
  always @(posedge clk or posedge rst)
    if (rst) begin
      bus.ack_i <= 1'b0;
      bus.data_i <= '0;
      wcnt <= 0;
    end else if (bus.cyc_o && bus.stb_o && !nack) begin
      if (wcnt < (bus.addr_o == delay_addr ? delay_n : 0)) begin
        wcnt <= wcnt + 1;
        bus.ack_i <= 1'b0;
      end else begin
        bus.ack_i <= 1'b1;
        if (bus.we_o) mem[bus.addr_o[13:2]] <= bus.data_o;
        bus.data_i <= mem[bus.addr_o[13:2]];
      end
    end else begin
      bus.ack_i <= 1'b0;
      wcnt <= 0;
    end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] data;} beat_t;
  typedef struct packed {logic [1:0] idx; logic [31:0] data;} fill_t;
  typedef struct {int lat; logic err;} done_t;
  beat_t beat_q[$];
  fill_t fill_q[$];
  done_t done_q[$];
  beat_t b;
  fill_t f;
  done_t d;
  int checks = 0, errors = 0;
  int start_cyc = 0, stb_cycles = 0;
  logic prev_stb = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (bus.stb_o) stb_cycles++;
      if (bus.stb_o && prev_stb) chk("addr_stable", bus.addr_o, prev_addr);
      prev_stb = bus.stb_o;
      prev_addr = bus.addr_o;
      if (bus.stb_o && bus.ack_i) begin
        if (beat_q.size() == 0) flag("unexpected_beat", bus.addr_o);
        else begin
          b = beat_q.pop_front();
          chk("beat_addr", bus.addr_o, b.addr);
          chk("beat_we", bus.we_o, b.we);
          chk("beat_sel", bus.sel_o, 4'hF);
          if (b.we) chk("beat_wdata", bus.data_o, b.data);
        end
      end
      if (fill_we_o) begin
        if (fill_q.size() == 0) flag("unexpected_fill", fill_data_o);
        else begin
          f = fill_q.pop_front();
          chk("fill_idx", fill_idx_o, f.idx);
          chk("fill_data", fill_data_o, f.data);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) flag("unexpected_done", cyc_n);
        else begin
          d = done_q.pop_front();
          chk("done_latency", cyc_n - start_cyc + 1, d.lat);
          chk("done_err", err_o, d.err);
        end
      end
    end

  task automatic expect_line(input logic we, input logic [31:0] base, input logic [31:0] dv [4], input int lat);
    for (int i = 0; i < WORDS; i++) begin
      beat_q.push_back('{base + 32'(4 * i), we, dv[i]});
      if (!we) fill_q.push_back('{2'(i), dv[i]});
    end
    done_q.push_back('{lat, 1'b0});
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input bit hold);
    @(negedge clk);
    chk("ready_before_req", req_ready_o, 1);
    req_i = 1'b1;
    req_we_i = we;
    req_addr_i = addr;
    @(posedge clk);
    #1;
    start_cyc = cyc_n;
    if (!hold) req_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((done_q.size() + beat_q.size() + fill_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout: %0d expectations left, expected 0", name, done_q.size() + beat_q.size() + fill_q.size());
      done_q.delete();
      beat_q.delete();
      fill_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < WORDS; i++) mem[12'h48C + i] = rd[i];
    cache_line = wd;
    @(negedge clk);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cyc", bus.cyc_o, 0);
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_fill_we", fill_we_o, 0);
    chk("rst_addr", bus.addr_o, 0);
    rst = 1'b0;

    expect_line(1'b0, 32'h1230, rd, 12);
    issue(1'b0, 32'h0000_1234, 1'b0);
    drain("refill");

    expect_line(1'b1, 32'h2000, wd, 12);
    issue(1'b1, 32'h0000_2000, 1'b0);
    drain("writeback");
    for (int i = 0; i < WORDS; i++) chk("ram_readback", mem[12'h800 + i], wd[i]);

    expect_line(1'b0, 32'h1230, rd, 12);
    issue(1'b0, 32'h0000_1238, 1'b1);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      chk("held_ready_low", req_ready_o, 0);
      if (done_o) break;
    end
    req_i = 1'b0;
    @(negedge clk);
    chk("held_ready_back", req_ready_o, 1);
    repeat (3) @(negedge clk);
    chk("held_single_txn", busy_o, 0);
    drain("held");

    delay_addr = 32'h1234;
    delay_n = 3;
    stb_cycles = 0;
    expect_line(1'b0, 32'h1230, rd, 15);
    issue(1'b0, 32'h0000_123C, 1'b0);
    drain("delay");
    chk("delay_stb_cycles", stb_cycles, 11);
    delay_n = 0;

    beat_q.push_back('{32'h1230, 1'b0, 32'h0});
    fill_q.push_back('{2'd0, 32'hA0});
    issue(1'b0, 32'h0000_1230, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_beat2_stb", bus.stb_o, 1);
    chk("mid_beat2_addr", bus.addr_o, 32'h1234);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_cyc", bus.cyc_o, 0);
    chk("mid_rst_stb", bus.stb_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", req_ready_o, 1);
    chk("mid_rst_done", done_o, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_queue", beat_q.size() + fill_q.size(), 0);
    expect_line(1'b0, 32'h1230, rd, 12);
    issue(1'b0, 32'h0000_1230, 1'b0);
    drain("after_rst");

`ifdef BUS_TIMEOUT_EN
    nack = 1'b1;
    stb_cycles = 0;
    done_q.push_back('{17, 1'b1});
    issue(1'b0, 32'h0000_1230, 1'b0);
    drain("timeout");
    chk("timeout_stb_cycles", stb_cycles, 16);
    nack = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_bus_master.md
# cache_bus_master

Bus initiator for the L1 cache controller. It turns cache line-refill and line-writeback requests into sequences of single-word strobe/acknowledge transactions toward the word-addressed data RAM slave. It sits between the cache FSM and the memory bus. It owns the bus signals cyc/stb/we/sel/addr/data, counts beats, and returns refill words to the cache data array one at a time.

## Interface
- WORDS, 4, words per cache line (power of two, 2..16)
- TIMEOUT, 16, cycles to wait for ack per beat (used only with BUS_TIMEOUT_EN)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_i  in  1  cache request strobe, sampled only when req_ready_o=1
- req_we_i  in  1  0 = refill (bus reads), 1 = writeback (bus writes)
- req_addr_i  in  32  any byte address inside the target line
- req_ready_o  out  1  block idle and able to accept req_i
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle pulse at the end of a transaction
- err_o  out  1  one-cycle pulse with done_o on timeout abort
- wb_idx_o  out  log2(WORDS)  writeback word index being fetched from the cache
- wb_data_i  in  32  cache word at wb_idx_o (combinational read by the cache)
- fill_we_o  out  1  one-cycle pulse: write fill_data_o into the line at fill_idx_o
- fill_idx_o  out  log2(WORDS)  refill word index
- fill_data_o  out  32  refill word
- cyc_o, stb_o, we_o  out  1 each  bus cycle, strobe, write enable
- sel_o  out  4  byte selects, always 4'hF
- addr_o  out  32  byte address, word-aligned
- data_o  out  32  write data
- data_i  in  32  read data from slave
- ack_i  in  1  slave acknowledge (registered in slave, one cycle after stb)

## Operation
- Reset values: all outputs 0 except req_ready_o=1. State = IDLE, beat counter = 0. Reset takes effect immediately, mid-transaction included, and drops cyc_o/stb_o the same instant.
- States:
  - IDLE
    - req_ready_o=1.
    - On req_i: latch line base = req_addr_i with bits [log2(WORDS)+1:0] cleared. Latch req_we_i. Set idx=0. Go to BEAT.
  - BEAT
    - cyc_o=stb_o=1, we_o=latched we, addr_o = base + 4*idx, sel_o=4'hF.
    - For writes, data_o is loaded from wb_data_i on entry to BEAT; wb_idx_o=idx throughout.
    - Stays in BEAT until ack_i=1.
    - On ack_i: for a read, assert fill_we_o for one cycle with fill_idx_o=idx and fill_data_o=data_i. If idx=WORDS-1, go to DONE; otherwise idx+1 and go to GAP.
  - GAP
    - cyc_o=1, stb_o=0. ack_i is ignored; it is still high here from the slave's repeat access. Go to BEAT.
  - DONE
    - cyc_o=stb_o=0, done_o=1 for one cycle. Go to IDLE.
- Because stb_o is registered, the slave performs the same access once more in the cycle ack is seen. That is a duplicate read, or a duplicate write with the same address and data. This is accepted behaviour, not an error.
- idx width is log2(WORDS). Address arithmetic is 32-bit and never carries out of the line.
- req_i while busy: ignored, never queued.
- busy_o=1 in BEAT, GAP and DONE.

## Timing
- Against a slave that acks one cycle after stb: BEAT lasts 2 cycles and GAP 1, so 3 cycles per beat. The last beat goes straight to DONE.
- Request accepted at edge E0 → done_o high in cycle 3*WORDS after E0 (WORDS=4: cycle 12).
- fill_we_o is high in the cycle after the ack cycle, registered with fill data.
- req_ready_o rises in the cycle after done_o. Back-to-back requests have one IDLE cycle minimum between them.
- A slow slave extends BEAT by the extra wait cycles; the rest of the schedule is unchanged.

## Configuration
- BUS_TIMEOUT_EN
  - Defined: a counter is cleared on entry to BEAT and counts BEAT cycles without ack_i. When it reaches TIMEOUT, the transaction is aborted: cyc_o/stb_o go low next cycle, state goes to DONE, and err_o is pulsed together with done_o. No further fill_we_o pulses are issued. Counter width is log2(TIMEOUT)+1.
  - Undefined: no counter; BEAT waits for ack_i indefinitely. err_o is tied 0.

## Test plan
- Refill, WORDS=4, req_addr_i=0x0000_1234, RAM words 0x1230..0x123C preloaded with 0xA0..0xA3 → addr_o sequence 0x1230, 0x1234, 0x1238, 0x123C. Four fill_we_o pulses with idx 0..3 and data 0xA0..0xA3. done_o in cycle 12; err_o=0.
- Writeback to 0x0000_2000 with cache words 0x11111111..0x44444444 → four bus writes, we_o=1, sel_o=4'hF. RAM reads back the same values. No fill_we_o.
- req_i held high through a transaction → exactly one transaction. req_ready_o=0 from E0+1 through the done_o cycle; the second request is accepted only after IDLE returns.
- Slave with ack delayed 3 extra cycles on beat 2 → stb_o held and addr_o stable through the wait. Total latency 15 cycles; data correct.
- rst asserted in beat 2 of a refill → cyc_o/stb_o/busy_o drop immediately, no done_o, req_ready_o=1. A new request then completes normally.
- BUS_TIMEOUT_EN, TIMEOUT=16, slave never acks → cyc_o deasserts after 16 BEAT cycles. done_o and err_o pulse together; no fill_we_o pulses.
